// File: rtl/fetch_pack_stage_pkg.sv
// fetch_pack_stage shared types.
// Fetch/decode widths and the pack FSM state encoding.
package fetch_pack_stage_pkg;

  localparam int FETCH_WIDTH  = 4;
  localparam int DECODE_WIDTH = 2;
  localparam int INST_WIDTH   = 32;

  typedef logic [INST_WIDTH-1:0] inst_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    LAST  = 2'd2
  } pack_state_e;

endpackage

// File: rtl/fetch_pack_stage_mask_compact4.sv
// mask_compact4: squeezes masked-off slots out of a fetch group.
// Slot i lands at popcount(mask[i-1:0]); n is the total popcount.
module mask_compact4
  import fetch_pack_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [FETCH_WIDTH-1:0]                 mask,
  input  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] data,
  output logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] cdata,
  output logic [2:0]                             n
);

  always_comb begin
    cdata = '0;
    n     = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (mask[i]) begin
        cdata[n[1:0]] = data[i];
        n             = n + 3'd1;
      end
    end
  end

endmodule

// File: rtl/fetch_pack_stage.sv
// fetch_pack_stage: repacks masked 4-wide fetch groups
// into dense 2-lane beats for the instruction buffer.
module fetch_pack_stage
  import fetch_pack_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IN_PORT    = FETCH_WIDTH,
  parameter int OUT_PORT   = DECODE_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [IN_PORT-1:0]                 in_mask_i,
  input  logic [IN_PORT-1:0][DATA_WIDTH-1:0] in_data_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [1:0]                         out_num_o,
  output logic [OUT_PORT-1:0][DATA_WIDTH-1:0] out_data_o
);

  pack_state_e state_q;
  logic        phase_q;
  logic [2:0]  n_q;
  logic [IN_PORT-1:0][DATA_WIDTH-1:0] hold_q;

  logic [IN_PORT-1:0][DATA_WIDTH-1:0] cdata;
  logic [2:0] n;
  logic       xfer;
  logic       load;

  mask_compact4 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_compact (
    .mask  (in_mask_i),
    .data  (in_data_i),
    .cdata (cdata),
    .n     (n)
  );

  assign xfer = out_valid_o & out_ready_i;

  assign in_ready_o = (state_q == IDLE) |
                      ((state_q == LAST) & out_ready_i);

  // In LAST, accepting implies out_ready_i, so the current
  // beat always leaves on the same edge a new group loads.
  assign load = in_valid_i & in_ready_o & ~flush_i &
                (n != 3'd0);

  assign out_data_o[0] = phase_q ? hold_q[2] : hold_q[0];
  assign out_data_o[1] = phase_q ? hold_q[3] : hold_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      n_q         <= '0;
      hold_q      <= '0;
      out_valid_o <= 1'b0;
      out_num_o   <= '0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      out_valid_o <= 1'b0;
      out_num_o   <= '0;
    end else if (load) begin
      hold_q      <= cdata;
      n_q         <= n;
      phase_q     <= 1'b0;
      out_valid_o <= 1'b1;
      if (n > 3'd2) begin
        state_q   <= FIRST;
        out_num_o <= 2'd2;
      end else begin
        state_q   <= LAST;
        out_num_o <= n[1:0];
      end
    end else begin
      unique case (state_q)
        IDLE: ;
        FIRST: begin
          if (xfer) begin
            state_q   <= LAST;
            phase_q   <= 1'b1;
            out_num_o <= 2'(n_q - 3'd2);
          end
        end
        LAST: begin
          if (xfer) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            out_valid_o <= 1'b0;
            out_num_o   <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_o <= 1'b0;
          out_num_o   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pack_stage.sv
// Bench for fetch_pack_stage: vector table plus hand sequences,
// beats checked against a scoreboard queue.
module tb_fetch_pack_stage;

  logic             clk;
  logic             rst_n;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       in_mask_i;
  logic [3:0][31:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [1:0]       out_num_o;
  logic [1:0][31:0] out_data_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          num;
    logic [31:0] d0;
    logic [31:0] d1;
  } beat_t;

  typedef struct {
    logic [3:0] mask;
    int nb;
    int n0; int a0; int b0;
    int n1; int a1; int b1;
  } vec_t;

  beat_t q[$];
  vec_t  tbl[12];

  fetch_pack_stage #(
    .DATA_WIDTH(32),
    .IN_PORT   (4),
    .OUT_PORT  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_mask_i   (in_mask_i),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_num_o   (out_num_o),
    .out_data_o  (out_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dv(int g, int s);
    return 32'hD000_0000 | 32'(g << 8) | 32'(s);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_beat(int num, logic [31:0] d0, logic [31:0] d1);
    beat_t b;
    b.num = num; b.d0 = d0; b.d1 = d1;
    q.push_back(b);
  endtask

  task automatic set_group(logic [3:0] m, int g);
    in_valid_i = 1'b1;
    in_mask_i  = m;
    for (int s = 0; s < 4; s++) in_data_i[s] = dv(g, s);
  endtask

  // Present a group, wait for acceptance (bounded), then deassert.
  task automatic drive_group(logic [3:0] m, int g);
    int t;
    @(posedge clk); #1;
    set_group(m, g);
    t = 0;
    @(negedge clk);
    while (!in_ready_o && t < 30) begin
      @(posedge clk); #1;
      @(negedge clk);
      t++;
    end
    if (t >= 30) begin
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  // Beats leave on the following posedge when valid & ready here.
  always @(negedge clk) begin
    if (rst_n && out_valid_o) begin
      checks++;
      if (out_num_o == 2'd0) begin
        errors++;
        $display("FAIL num_zero: got 0 expected 1..2");
      end
      if (out_ready_i) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h expected none", out_data_o[0]);
        end else begin
          beat_t b;
          b = q.pop_front();
          chk("beat_num", 32'(out_num_o), 32'(b.num));
          chk("beat_lane0", out_data_o[0], b.d0);
          if (b.num == 2) chk("beat_lane1", out_data_o[1], b.d1);
        end
      end
    end
  end

  task automatic drain(string name);
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk(name, 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [3:0] sm[6];
    logic [31:0] h0;
    logic [31:0] h1;

    tbl[0]  = '{4'b1010, 1, 2, 1, 3, 0, 0, 0};
    tbl[1]  = '{4'b1111, 2, 2, 0, 1, 2, 2, 3};
    tbl[2]  = '{4'b0111, 2, 2, 0, 1, 1, 2, 0};
    tbl[3]  = '{4'b0011, 1, 2, 0, 1, 0, 0, 0};
    tbl[4]  = '{4'b0000, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{4'b0001, 1, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{4'b1000, 1, 1, 3, 0, 0, 0, 0};
    tbl[7]  = '{4'b0110, 1, 2, 1, 2, 0, 0, 0};
    tbl[8]  = '{4'b1101, 2, 2, 0, 2, 1, 3, 0};
    tbl[9]  = '{4'b1011, 2, 2, 0, 1, 1, 3, 0};
    tbl[10] = '{4'b0101, 1, 2, 0, 2, 0, 0, 0};
    tbl[11] = '{4'b1110, 2, 2, 1, 2, 1, 3, 0};

    rst_n       = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_mask_i   = '0;
    in_data_i   = '0;
    out_ready_i = 1'b1;
    #12 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_num", 32'(out_num_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);

    // Vector table with the sink always ready.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].nb >= 1)
        push_beat(tbl[i].n0, dv(i, tbl[i].a0), dv(i, tbl[i].b0));
      if (tbl[i].nb == 2)
        push_beat(tbl[i].n1, dv(i, tbl[i].a1), dv(i, tbl[i].b1));
      drive_group(tbl[i].mask, i);
    end
    drain("table_drain");

    // 4'b1111: in_ready low while the first beat is presented.
    push_beat(2, dv(20, 0), dv(20, 1));
    push_beat(2, dv(20, 2), dv(20, 3));
    drive_group(4'b1111, 20);
    chk("first_in_ready", 32'(in_ready_o), 32'd0);
    drain("full_drain");

    // 4'b0111 with a 3-cycle stall: FIRST beat must hold.
    out_ready_i = 1'b0;
    push_beat(2, dv(30, 0), dv(30, 1));
    push_beat(1, dv(30, 2), dv(30, 0));
    drive_group(4'b0111, 30);
    @(negedge clk);
    h0 = out_data_o[0];
    h1 = out_data_o[1];
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid", 32'(out_valid_o), 32'd1);
      chk("stall_lane0", out_data_o[0], dv(30, 0));
      chk("stall_lane1", out_data_o[1], dv(30, 1));
      chk("stall_stable", out_data_o[0] ^ h0 | out_data_o[1] ^ h1, 32'd0);
      chk("stall_in_ready", 32'(in_ready_o), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    drain("stall_drain");
    @(posedge clk); #1;
    chk("stall_idle", 32'(out_valid_o), 32'd0);

    // Back-to-back 2-slot groups, one empty group in the middle.
    sm[0] = 4'b0011; sm[1] = 4'b0011; sm[2] = 4'b0011;
    sm[3] = 4'b0000; sm[4] = 4'b0011; sm[5] = 4'b0011;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      set_group(sm[k], 40 + k);
      @(negedge clk);
      chk("stream_in_ready", 32'(in_ready_o), 32'd1);
      if (k > 0)
        chk("stream_valid", 32'(out_valid_o), 32'(sm[k-1] != 4'b0000));
      if (sm[k] != 4'b0000) push_beat(2, dv(40 + k, 0), dv(40 + k, 1));
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    drain("stream_drain");

    // Flush while in FIRST with a new group offered.
    out_ready_i = 1'b0;
    drive_group(4'b1111, 50);
    chk("flush_pre_ready", 32'(in_ready_o), 32'd0);
    q.delete();
    flush_i = 1'b1;
    set_group(4'b0011, 51);
    @(posedge clk); #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    chk("flush_valid", 32'(out_valid_o), 32'd0);
    chk("flush_in_ready", 32'(in_ready_o), 32'd1);
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("flush_quiet", 32'(out_valid_o), 32'd0);

    // Asynchronous reset mid-FIRST.
    out_ready_i = 1'b0;
    drive_group(4'b1111, 60);
    chk("pre_rst_valid", 32'(out_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_o), 32'd0);
    chk("arst_num", 32'(out_num_o), 32'd0);
    chk("arst_in_ready", 32'(in_ready_o), 32'd1);
    q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready_i = 1'b1;
    push_beat(2, dv(61, 1), dv(61, 2));
    push_beat(1, dv(61, 3), dv(61, 0));
    drive_group(4'b1110, 61);
    drain("post_rst_drain");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
